// File: rtl/oib_endpoint.sv
`timescale 1ns/1ps
// oib_endpoint: byte-serial command endpoint with odd parity.
// Receives CMD/ADDR/WDATA frames on ob_*, issues one local memory access,
// and answers with a status byte, plus 4 read-data bytes for a successful read.
module oib_endpoint #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ob_data,
    input  logic        ob_pty,
    output logic [7:0]  ib_data,
    output logic        ib_pty,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_WDATA  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_STATUS = 3'd4;
    localparam logic [2:0] S_RDATA  = 3'd5;

    localparam logic [7:0] ST_OK  = 8'h80;
    localparam logic [7:0] ST_PAR = 8'h81;
    localparam logic [7:0] ST_CMD = 8'h82;
    localparam logic [7:0] ST_TMO = 8'h83;

    localparam logic [7:0] CMD_IDLE  = 8'h00;
    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // The access gives up on the cycle whose count would reach TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [1:0]  r_cnt;      // byte index within ADDR, WDATA and RDATA phases
    logic [7:0]  r_tcnt;     // ACCESS cycles spent without ack
    logic [7:0]  r_status;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_req;
    logic [7:0]  r_ib_data;
    logic        r_ib_pty;

    logic        w_ob_ok;
    logic [4:0]  w_byte_base;
    logic [7:0]  w_rd_byte;

    // Odd parity holds when {pty,data} has an odd number of ones.
    assign w_ob_ok     = ^{ob_pty, ob_data};
    assign w_byte_base = {r_cnt, 3'b000};
    assign w_rd_byte   = r_rdata[w_byte_base +: 8];

    // Frame decode, access handshake and response sequencing.
    // NOTE: every register here uses <= so all branches see the pre-edge values
    // of r_cnt/r_state; a blocking update would make byte placement order-dependent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 2'd0;
            r_tcnt    <= 8'd0;
            r_status  <= 8'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_req     <= 1'b0;
            r_ib_data <= 8'h00;
            r_ib_pty  <= 1'b1;
        end else begin
            // Idle symbol on the response bus unless STATUS/RDATA override it.
            r_ib_data <= 8'h00;
            r_ib_pty  <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (!w_ob_ok) begin
                        r_status <= ST_PAR;
                        r_state  <= S_STATUS;
                    end else if (ob_data == CMD_READ || ob_data == CMD_WRITE) begin
                        r_we    <= (ob_data == CMD_WRITE);
                        r_cnt   <= 2'd0;
                        r_state <= S_ADDR;
                    end else if (ob_data != CMD_IDLE) begin
                        r_status <= ST_CMD;
                        r_state  <= S_STATUS;
                    end
                end

                S_ADDR: begin
                    if (!w_ob_ok) begin
                        r_status <= ST_PAR;
                        r_state  <= S_STATUS;
                    end else begin
                        r_addr[w_byte_base +: 8] <= ob_data;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            if (r_we) begin
                                r_state <= S_WDATA;
                            end else begin
                                // Request rises together with the last address byte.
                                r_req   <= 1'b1;
                                r_tcnt  <= 8'd0;
                                r_state <= S_ACCESS;
                            end
                        end
                    end
                end

                S_WDATA: begin
                    if (!w_ob_ok) begin
                        r_status <= ST_PAR;
                        r_state  <= S_STATUS;
                    end else begin
                        r_wdata[w_byte_base +: 8] <= ob_data;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_req   <= 1'b1;
                            r_tcnt  <= 8'd0;
                            r_state <= S_ACCESS;
                        end
                    end
                end

                S_ACCESS: begin
                    // Ack is checked first so an ack on the timeout cycle still succeeds.
                    if (mem_ack) begin
                        r_req    <= 1'b0;
                        r_status <= ST_OK;
                        if (!r_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_state  <= S_STATUS;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                        if (r_tcnt == TMO_LAST) begin
                            r_req    <= 1'b0;
                            r_status <= ST_TMO;
                            r_state  <= S_STATUS;
                        end
                    end
                end

                S_STATUS: begin
                    r_ib_data <= r_status;
                    r_ib_pty  <= ~^r_status;
                    r_cnt     <= 2'd0;
                    if (!r_we && r_status == ST_OK) begin
                        r_state <= S_RDATA;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_RDATA: begin
                    r_ib_data <= w_rd_byte;
                    r_ib_pty  <= ~^w_rd_byte;
                    r_cnt     <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ib_data   = r_ib_data;
    assign ib_pty    = r_ib_pty;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_oib_endpoint.sv
`timescale 1ns/1ps
// Directed testbench for oib_endpoint (TIMEOUT=4): per-cycle vector table
// with hand-computed expectations, plus hand-written reset sequences.
module tb_oib_endpoint;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ob_data;
    logic        ob_pty;
    logic [7:0]  ib_data;
    logic        ib_pty;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    oib_endpoint #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ob_data   (ob_data),
        .ob_pty    (ob_pty),
        .ib_data   (ib_data),
        .ib_pty    (ib_pty),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [7:0]  ob;
        logic        bad;       // send ob with flipped parity
        logic        ack;
        logic [31:0] rdata;
        logic        exp_req;
        logic [7:0]  exp_ib;
        logic        exp_busy;
        logic        chk_addr;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic        chk_wd;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] cur_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] ob, input logic bad, input logic ack,
                       input logic req, input logic [7:0] ib, input logic bsy);
        vec_t v;
        v.rst = r; v.ob = ob; v.bad = bad; v.ack = ack; v.rdata = cur_rdata;
        v.exp_req = req; v.exp_ib = ib; v.exp_busy = bsy;
        v.chk_addr = 1'b0; v.exp_we = 1'b0; v.exp_addr = 32'h0;
        v.chk_wd = 1'b0; v.exp_wdata = 32'h0;
        vq.push_back(v);
    endtask

    // Attach address/direction expectations to the most recent vector.
    task automatic exp_mem(input logic we, input logic [31:0] addr);
        vq[vq.size()-1].chk_addr = 1'b1;
        vq[vq.size()-1].exp_we   = we;
        vq[vq.size()-1].exp_addr = addr;
    endtask

    task automatic exp_wd(input logic [31:0] wd);
        vq[vq.size()-1].chk_wd    = 1'b1;
        vq[vq.size()-1].exp_wdata = wd;
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic r, input logic [7:0] ob, input logic bad,
                        input logic ack, input logic [31:0] rd);
        rst       = r;
        ob_data   = ob;
        ob_pty    = bad ? ^ob : ~^ob;
        mem_ack   = ack;
        mem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ib(input string name, input logic [7:0] exp);
        check({name, ".ib_data"}, {24'h0, ib_data}, {24'h0, exp});
        check({name, ".ib_pty"}, {31'h0, ib_pty}, {31'h0, ~^exp});
    endtask

    initial begin
        rst = 1'b1; ob_data = 8'h00; ob_pty = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;

        // ---- reset and idle ----
        add(1, 8'h00, 0, 0, 0, 8'h00, 0);
        exp_mem(0, 32'h0); exp_wd(32'h0);
        add(0, 8'h00, 0, 0, 0, 8'h00, 0);

        // ---- write 0xDEADBEEF to 0x12345678, ack on the 3rd access cycle ----
        add(0, 8'h02, 0, 0, 0, 8'h00, 1);
        add(0, 8'h78, 0, 0, 0, 8'h00, 1);
        add(0, 8'h56, 0, 0, 0, 8'h00, 1);
        add(0, 8'h34, 0, 0, 0, 8'h00, 1);
        add(0, 8'h12, 0, 0, 0, 8'h00, 1);
        add(0, 8'hEF, 0, 0, 0, 8'h00, 1);
        add(0, 8'hBE, 0, 0, 0, 8'h00, 1);
        add(0, 8'hAD, 0, 0, 0, 8'h00, 1);
        add(0, 8'hDE, 0, 0, 1, 8'h00, 1);
        exp_mem(1, 32'h12345678); exp_wd(32'hDEADBEEF);
        add(0, 8'h00, 0, 0, 1, 8'h00, 1);
        exp_mem(1, 32'h12345678); exp_wd(32'hDEADBEEF);
        add(0, 8'h00, 0, 0, 1, 8'h00, 1);
        exp_mem(1, 32'h12345678); exp_wd(32'hDEADBEEF);
        add(0, 8'h00, 0, 1, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h80, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, 0);

        // ---- read 0x00000010 -> 0xCAFEF00D; junk bytes during access/status ignored ----
        cur_rdata = 32'hCAFEF00D;
        add(0, 8'h01, 0, 0, 0, 8'h00, 1);
        add(0, 8'h10, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 8'h00, 1);
        exp_mem(0, 32'h00000010);
        add(0, 8'h33, 1, 0, 1, 8'h00, 1);
        exp_mem(0, 32'h00000010);
        add(0, 8'h00, 0, 1, 0, 8'h00, 1);
        add(0, 8'h07, 0, 0, 0, 8'h80, 1);
        add(0, 8'h55, 1, 0, 0, 8'h0D, 1);
        add(0, 8'h00, 0, 0, 0, 8'hF0, 1);
        add(0, 8'h00, 0, 0, 0, 8'hFE, 1);
        add(0, 8'h00, 0, 0, 0, 8'hCA, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, 0);

        // ---- flipped parity on the third frame byte ----
        add(0, 8'h02, 0, 0, 0, 8'h00, 1);
        add(0, 8'h78, 0, 0, 0, 8'h00, 1);
        add(0, 8'h56, 1, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h81, 0);
        add(0, 8'h00, 0, 1, 0, 8'h00, 0);

        // ---- bad command ----
        add(0, 8'h07, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h82, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, 0);

        // ---- never-acked read: mem_req high 4 cycles, then 0x83 ----
        add(0, 8'h01, 0, 0, 0, 8'h00, 1);
        add(0, 8'h40, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h83, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, 0);

        // ---- ack on the exact timeout cycle wins ----
        cur_rdata = 32'h1234A55A;
        add(0, 8'h01, 0, 0, 0, 8'h00, 1);
        add(0, 8'h44, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 8'h00, 1);
        add(0, 8'h00, 0, 1, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 8'h80, 1);
        add(0, 8'h00, 0, 0, 0, 8'h5A, 1);
        add(0, 8'h00, 0, 0, 0, 8'hA5, 1);
        add(0, 8'h00, 0, 0, 0, 8'h34, 1);
        add(0, 8'h00, 0, 0, 0, 8'h12, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, 0);

        foreach (vq[i]) begin
            string tag;
            step(vq[i].rst, vq[i].ob, vq[i].bad, vq[i].ack, vq[i].rdata);
            tag = $sformatf("v%0d", i);
            check({tag, ".mem_req"}, {31'h0, mem_req}, {31'h0, vq[i].exp_req});
            check({tag, ".busy"}, {31'h0, busy}, {31'h0, vq[i].exp_busy});
            check_ib(tag, vq[i].exp_ib);
            if (vq[i].chk_addr) begin
                check({tag, ".mem_we"}, {31'h0, mem_we}, {31'h0, vq[i].exp_we});
                check({tag, ".mem_addr"}, mem_addr, vq[i].exp_addr);
            end
            if (vq[i].chk_wd) begin
                check({tag, ".mem_wdata"}, mem_wdata, vq[i].exp_wdata);
            end
        end

        // ---- reset mid-frame: no status byte afterwards ----
        step(0, 8'h02, 0, 0, 32'h0);
        step(0, 8'h11, 0, 0, 32'h0);
        check("midframe.busy_before", {31'h0, busy}, 32'h1);
        step(1, 8'h22, 0, 0, 32'h0);
        check("midframe.busy_rst", {31'h0, busy}, 32'h0);
        step(0, 8'h00, 0, 0, 32'h0);
        check_ib("midframe.after", 8'h00);
        check("midframe.busy_after", {31'h0, busy}, 32'h0);

        // ---- reset mid-access, late ack ignored, then a normal read ----
        step(0, 8'h01, 0, 0, 32'h0);
        step(0, 8'h50, 0, 0, 32'h0);
        step(0, 8'h00, 0, 0, 32'h0);
        step(0, 8'h00, 0, 0, 32'h0);
        step(0, 8'h00, 0, 0, 32'h0);
        check("rstacc.req_before", {31'h0, mem_req}, 32'h1);
        step(1, 8'h00, 0, 0, 32'h0);
        check("rstacc.req_rst", {31'h0, mem_req}, 32'h0);
        check("rstacc.busy_rst", {31'h0, busy}, 32'h0);
        check("rstacc.addr_rst", mem_addr, 32'h0);
        check_ib("rstacc.rst", 8'h00);
        step(0, 8'h00, 0, 1, 32'hFFFFFFFF);
        check("rstacc.late_ack_req", {31'h0, mem_req}, 32'h0);
        check("rstacc.late_ack_busy", {31'h0, busy}, 32'h0);
        step(0, 8'h00, 0, 0, 32'h0);
        check_ib("rstacc.idle", 8'h00);
        step(0, 8'h01, 0, 0, 32'h0);
        step(0, 8'h60, 0, 0, 32'h0);
        step(0, 8'h00, 0, 0, 32'h0);
        step(0, 8'h00, 0, 0, 32'h0);
        step(0, 8'h00, 0, 0, 32'h0);
        check("rstacc.req2", {31'h0, mem_req}, 32'h1);
        check("rstacc.addr2", mem_addr, 32'h00000060);
        check("rstacc.we2", {31'h0, mem_we}, 32'h0);
        step(0, 8'h00, 0, 1, 32'h0BADF00D);
        check("rstacc.req_ack", {31'h0, mem_req}, 32'h0);
        step(0, 8'h00, 0, 0, 32'h0);
        check_ib("rstacc.status", 8'h80);
        step(0, 8'h00, 0, 0, 32'h0);
        check_ib("rstacc.rd0", 8'h0D);
        step(0, 8'h00, 0, 0, 32'h0);
        check_ib("rstacc.rd1", 8'hF0);
        step(0, 8'h00, 0, 0, 32'h0);
        check_ib("rstacc.rd2", 8'hAD);
        step(0, 8'h00, 0, 0, 32'h0);
        check_ib("rstacc.rd3", 8'h0B);
        check("rstacc.busy_end", {31'h0, busy}, 32'h0);
        step(0, 8'h00, 0, 0, 32'h0);
        check_ib("rstacc.idle_end", 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oib_endpoint.md
OIB_ENDPOINT -- requirements
Module: oib_endpoint

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum number of cycles mem_req may stay asserted without mem_ack.
REQ-002 SHALL use reset rst, synchronous, active-high, and clock clk; all state updates occur on posedge clk.
REQ-003 clk  in  1  byte-bus and local-port clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ob_data  in  8  outbound byte from the core, sampled every clk edge.
REQ-006 ob_pty  in  1  odd parity over ob_data.
REQ-007 ib_data  out  8  inbound response byte to the core, registered.
REQ-008 ib_pty  out  1  odd parity over ib_data, registered.
REQ-009 mem_req  out  1  local access request, registered.
REQ-010 mem_we  out  1  1=write, 0=read; valid while mem_req is high.
REQ-011 mem_addr  out  32  access address; valid while mem_req is high.
REQ-012 mem_wdata  out  32  write data; valid while mem_req is high.
REQ-013 mem_ack  in  1  one-cycle access completion.
REQ-014 mem_rdata  in  32  read data; valid when mem_ack is high.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 Odd parity is the rule in both directions: the number of ones in {pty,data} SHALL be odd; the idle symbol is data 0x00, pty 1.
REQ-017 Frame: CMD byte, then 4 ADDR bytes LSB first, then (CMD=0x02 only) 4 WDATA bytes LSB first, all on consecutive cycles; CMD 0x01=read, 0x02=write.
REQ-018 FSM states: IDLE, ADDR, WDATA, ACCESS, STATUS, RDATA.
REQ-019 IDLE: a correct-parity byte 0x00 is idle and is ignored; 0x01 or 0x02 -> ADDR; any other correct-parity byte -> STATUS with status 0x82 (bad command), no access.
REQ-020 A byte with wrong parity in IDLE, ADDR or WDATA SHALL abort the frame -> STATUS with status 0x81; no mem_req is issued.
REQ-021 ADDR collects 4 bytes with a 2-bit counter that wraps 3->0; after the 4th byte, go to WDATA (write) or ACCESS (read).
REQ-022 WDATA collects 4 bytes the same way, then -> ACCESS.
REQ-023 mem_req SHALL rise on the edge that samples the last frame byte and stay high until the edge that samples mem_ack=1 (inclusive); mem_addr, mem_we and mem_wdata stay stable throughout.
REQ-024 mem_ack while mem_req is low SHALL be ignored.
REQ-025 An 8-bit timeout counter clears on entry to ACCESS and increments every ACCESS cycle without ack; when it reaches TIMEOUT, mem_req drops -> STATUS with status 0x83.
REQ-026 mem_ack in the same cycle the counter reaches TIMEOUT SHALL win: the access is treated as successful.
REQ-027 On ack, status is 0x80; for a read, mem_rdata is captured on that same edge.
REQ-028 STATUS drives the status byte with correct parity for exactly 1 cycle, then goes to RDATA (read with status 0x80) or IDLE (all other cases).
REQ-029 RDATA drives the 4 captured bytes LSB first on consecutive cycles, then -> IDLE.
REQ-030 Outside STATUS and RDATA, ib_data/ib_pty SHALL be 0x00/1.
REQ-031 Bytes arriving in ACCESS, STATUS or RDATA SHALL be ignored, including bytes with bad parity.
REQ-032 Status-to-first-response latency: the ib status byte appears on the edge after the edge that samples mem_ack (or the bad byte, or the timeout).

Reset
REQ-033 rst SHALL force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ib_data=0x00, ib_pty=1, busy=0, and clear the counters and capture registers.
REQ-034 rst mid-frame or mid-access SHALL drop mem_req on the next edge, with no status byte emitted; a late mem_ack after reset is ignored.

Verification
REQ-035 Write: ob sequence 02,78,56,34,12,EF,BE,AD,DE with correct parity, mem_ack 3 cycles later -> mem_addr=0x12345678, mem_wdata=0xDEADBEEF, mem_we=1, then ib 80/pty0, then idle.
REQ-036 Read of address 0x00000010 with mem_rdata=0xCAFEF00D -> ib 80, 0D, F0, FE, CA on consecutive cycles, each with odd parity.
REQ-037 Third byte sent with flipped parity -> ib 81 one cycle later, mem_req never asserted.
REQ-038 CMD 0x07 -> ib 82; never acked read with TIMEOUT=4 -> mem_req high 4 cycles, then ib 83.
REQ-039 rst asserted while mem_req=1 -> mem_req=0 on the next edge, ib stays 00/1, busy=0; a subsequent valid read completes normally.
REQ-040 mem_ack arriving on the exact timeout cycle -> status 80 with data returned.
